// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a little-endian byte stream into BYTES-lane words with a keep mask
module byte_word_packer #(
  parameter int BYTES  = 4,
  parameter int BYTE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BYTES*BYTE_W-1:0] out_data,
  output logic [BYTES-1:0]        out_keep
);
  localparam int IW = $clog2(BYTES);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BYTES*BYTE_W-1:0] acc_q, acc_d, data_q, data_d;
  logic [BYTES-1:0] acc_keep_q, acc_keep_d, keep_q, keep_d;
  logic accept, done, consume;
  assign out_valid = state_q == HOLD;
  assign in_ready  = !out_valid || out_ready;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign accept    = in_valid && in_ready;
  assign done      = accept && (in_last || idx_q == IW'(BYTES-1));
  assign consume   = out_valid && out_ready;
  // Lanes above idx are always zero in acc, so the updated acc is the finished word.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    acc_keep_d = acc_keep_q;
    data_d     = data_q;
    keep_d     = keep_q;
    if (accept) begin
      acc_d[idx_q*BYTE_W +: BYTE_W] = in_data;
      acc_keep_d[idx_q]             = 1'b1;
      idx_d                         = idx_q + 1'b1;
    end
    if (done) begin
      data_d     = acc_d;
      keep_d     = acc_keep_d;
      acc_d      = '0;
      acc_keep_d = '0;
      idx_d      = '0;
      state_d    = HOLD;
    end else if (consume) begin
      state_d = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      idx_q      <= '0;
      acc_q      <= '0;
      acc_keep_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      acc_keep_q <= acc_keep_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
    end
  end
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: directed scenarios plus a randomized run against a byte-list reference model
module tb_byte_word_packer;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [7:0] in_data = 0;
  logic out_valid, out_ready = 1;
  logic [31:0] out_data;
  logic [3:0] out_keep;
  int passed = 0, total = 0;

  byte_word_packer #(.BYTES(4), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 1; drive(0, 0, 0);
    tick(); tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL reset_data got %h exp 00000000", out_data); else passed++;
    total++; if (out_keep !== 4'h0) $display("FAIL reset_keep got %h exp 0", out_keep); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else passed++;
    rst = 0;
  endtask

  task automatic test_full_word();
    logic [7:0] b [4] = '{8'haf, 8'hbe, 8'had, 8'hde};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 0);
      total++; if (in_ready !== 1'b1) $display("FAIL full_ready[%0d] got %b exp 1", i, in_ready); else passed++;
      tick();
    end
    drive(0, 0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL full_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 32'hdeadbeaf) $display("FAIL full_data got %h exp deadbeaf", out_data); else passed++;
    total++; if (out_keep !== 4'hf) $display("FAIL full_keep got %h exp f", out_keep); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL full_one_cycle got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_partial_flush();
    logic [7:0] b [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
    out_ready = 1;
    drive(1, 8'h11, 0); tick();
    drive(1, 8'h22, 1); tick();
    drive(0, 0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL partial_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 32'h00002211) $display("FAIL partial_data got %h exp 00002211", out_data); else passed++;
    total++; if (out_keep !== 4'b0011) $display("FAIL partial_keep got %b exp 0011", out_keep); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 0);
      tick();
    end
    drive(0, 0, 0);
    total++; if (out_data !== 32'h66554433) $display("FAIL wrap_data got %h exp 66554433", out_data); else passed++;
    total++; if (out_keep !== 4'hf) $display("FAIL wrap_keep got %h exp f", out_keep); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] b [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 0);
      tick();
    end
    drive(1, 8'haa, 0);
    for (int c = 0; c < 5; c++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", c, out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", c, in_ready); else passed++;
      total++; if (out_data !== 32'h01020304) $display("FAIL bp_data[%0d] got %h exp 01020304", c, out_data); else passed++;
      total++; if (out_keep !== 4'hf) $display("FAIL bp_keep[%0d] got %h exp f", c, out_keep); else passed++;
      tick();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else passed++;
    tick();
    drive(0, 0, 0);
    total++; if (out_valid !== 1'b0) $display("FAIL bp_consumed got %b exp 0", out_valid); else passed++;
    drive(1, 8'hbb, 1); tick();
    drive(0, 0, 0);
    total++; if (out_data !== 32'h0000bbaa) $display("FAIL bp_lane0_data got %h exp 0000bbaa", out_data); else passed++;
    total++; if (out_keep !== 4'b0011) $display("FAIL bp_lane0_keep got %b exp 0011", out_keep); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 0);
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); else passed++;
      if (i >= 4) begin
        total++; if (out_valid !== (i % 4 == 0)) $display("FAIL b2b_valid[%0d] got %b exp %b", i, out_valid, i % 4 == 0); else passed++;
        if (i % 4 == 0) begin
          exp = 0;
          for (int k = 0; k < 4; k++) exp |= 32'(i - 4 + k) << (8 * k);
          total++; if (out_data !== exp) $display("FAIL b2b_data[%0d] got %h exp %h", i, out_data, exp); else passed++;
        end
      end
      tick();
    end
    drive(0, 0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_last_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 32'h0f0e0d0c) $display("FAIL b2b_last_data got %h exp 0f0e0d0c", out_data); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    out_ready = 1;
    drive(1, 8'hff, 0); tick();
    drive(1, 8'hee, 0); tick();
    drive(0, 0, 0);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b0) $display("FAIL mid_no_early_word[%0d] got %b exp 0", i, out_valid); else passed++;
      drive(1, b[i], 0);
      tick();
    end
    drive(0, 0, 0);
    total++; if (out_data !== 32'h04030201) $display("FAIL mid_data got %h exp 04030201", out_data); else passed++;
    total++; if (out_keep !== 4'hf) $display("FAIL mid_keep got %h exp f", out_keep); else passed++;
    tick();
  endtask

  task automatic test_reset_holding();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h5a + 8'(i), 0);
      tick();
    end
    drive(0, 0, 0);
    total++; if (out_valid !== 1'b1) $display("FAIL hold_pre_valid got %b exp 1", out_valid); else passed++;
    rst = 1; tick(); rst = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL hold_rst_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 32'h0) $display("FAIL hold_rst_data got %h exp 00000000", out_data); else passed++;
    total++; if (out_keep !== 4'h0) $display("FAIL hold_rst_keep got %h exp 0", out_keep); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL hold_rst_ready got %b exp 1", in_ready); else passed++;
    out_ready = 1;
  endtask

  // Reference: pending bytes kept as a list; a word is the list placed lane by lane.
  task automatic test_random();
    logic [7:0] pend [$];
    logic m_valid = 0;
    logic [31:0] m_data = 0;
    logic [3:0] m_keep = 0;
    logic acc;
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(9, 0) < 7, 8'($urandom), $urandom_range(4, 0) == 0);
      out_ready = $urandom_range(9, 0) < 6;
      #1;
      total++; if (in_ready !== (!m_valid || out_ready)) $display("FAIL rnd_ready[%0d] got %b exp %b", c, in_ready, !m_valid || out_ready); else passed++;
      total++; if (out_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, m_valid); else passed++;
      if (m_valid) begin
        total++; if (out_data !== m_data) $display("FAIL rnd_data[%0d] got %h exp %h", c, out_data, m_data); else passed++;
        total++; if (out_keep !== m_keep) $display("FAIL rnd_keep[%0d] got %h exp %h", c, out_keep, m_keep); else passed++;
      end
      acc = in_valid && (!m_valid || out_ready);
      if (acc) pend.push_back(in_data);
      if (acc && (in_last || pend.size() == 4)) begin
        m_data = 0;
        foreach (pend[k]) m_data |= 32'(pend[k]) << (8 * k);
        m_keep = 4'((1 << pend.size()) - 1);
        m_valid = 1;
        pend.delete();
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      tick();
    end
    drive(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_reset_holding();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Assembles a little-endian byte stream into 32-bit words; the inverse of our word-to-byte indexed-part-select split.
- Byte k of a word lands at data[k*8 +: 8]. For example, the bytes af, be, ad, de produce 32'hdeadbeaf.
- Sits between byte-wide sources (UART RX, byte FIFOs) and word-wide consumers.
- Uses valid/ready handshakes on both sides. A last flag flushes a partial word with a byte-keep mask.

Parameters:
- BYTES, 4, number of bytes per output word (must be ≥ 2).
- BYTE_W, 8, width of one byte lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  packer accepts a byte this cycle.
- in_data  input  BYTE_W  byte value.
- in_last  input  1  this byte ends the word; flush even if partial.
- out_valid  output  1  out_data/out_keep hold a completed word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  BYTES*BYTE_W  assembled word; lane k = data[k*BYTE_W +: BYTE_W].
- out_keep  output  BYTES  bit k=1 means lane k was written.

Behaviour:
- Reset (rst=1 at a clk edge) sets every register to zero:
  - out_valid=0, out_data=0, out_keep=0.
  - Lane index idx=0, accumulator acc=0, acc_keep=0.
  - Any partial word is discarded, including a reset arriving mid-word or while out_valid is held.
- Handshake and flow control:
  - A byte is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready. The output register is a single slot with combinational back-pressure, and in_ready does not depend on in_valid.
  - The word is consumed when out_valid && out_ready.
- Lane fill and state: there are two states, FILL and HOLD; HOLD is out_valid=1.
  - On accept with idx < BYTES-1 and in_last=0: acc[idx*BYTE_W +: BYTE_W] <= in_data; acc_keep[idx] <= 1; idx <= idx+1.
  - On accept with idx == BYTES-1 or in_last=1, the word completes:
    - out_data <= acc with lane idx replaced by in_data.
    - out_keep <= acc_keep | (1<<idx).
    - out_valid <= 1.
    - acc <= 0, acc_keep <= 0, idx <= 0 (wrap).
  - Unwritten lanes of a partial word output as zero.
- Latency: out_valid rises the cycle after the completing byte is accepted.
- Throughput: one byte per cycle sustained when out_ready=1. A word completion and the consumption of the previous word in the same cycle are legal: the slot is reloaded and out_valid stays 1.
- Back-pressure: out_valid=1 with out_ready=0 forces in_ready=0. out_data and out_keep must stay stable while out_valid=1 and the word has not been consumed.
- Consume with no new completion: out_valid <= 0; out_data/out_keep keep their last value.
- in_last on lane BYTES-1 behaves identically to a full word.
- Bytes presented while in_ready=0 are not accepted; idx does not advance.
- in_data/in_last are ignored when in_valid=0.
- idx width is clog2(BYTES) and never exceeds BYTES-1.

Test Plan:
- Full word: reset, out_ready=1, send af, be, ad, de on consecutive cycles with in_last=0 → one cycle after de, out_valid=1, out_data=32'hdeadbeaf, out_keep=4'b1111, held for one cycle.
- Partial flush: send 11, then 22 with in_last=1 → out_data=32'h00002211, out_keep=4'b0011. The next bytes 33, 44, 55, 66 give 32'h66554433 with out_keep=4'hF, proving idx wrapped to 0.
- Back-pressure: complete word 01020304 (bytes 04, 03, 02, 01) with out_ready=0 → out_valid=1 and in_ready=0, and out_data=32'h01020304 is stable for 5 cycles while in_valid=1 with byte aa is held. When out_ready=1 the word is consumed and aa is accepted into lane 0 in that same cycle.
- Back-to-back stream: 16 bytes 00..0f, one per cycle, out_ready=1 → four words 32'h03020100, 07060504, 0b0a0908, 0f0e0d0c. in_ready stays 1 throughout, and there is no idle gap between words.
- Reset mid-word: send ff, ee, then assert rst for one cycle, then send 01, 02, 03, 04 → no output containing ff or ee; out_data=32'h04030201, out_keep=4'hF.
- Reset while holding: out_valid=1 with out_ready=0, assert rst → next cycle out_valid=0, out_data=0, out_keep=0, in_ready=1.
